// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC ownership, ROM addressing, instruction register with stall/redirect/boot handling

`ifndef NOP
`define NOP 8'h00
`endif

module instruction_fetch #(
  parameter int unsigned         ADDR_WIDTH   = 16,
  parameter int unsigned         INSTR_WIDTH  = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   iClock,
  input  logic                   iReset_n,
  output logic [ADDR_WIDTH-1:0]  oRomAddress,
  input  logic [INSTR_WIDTH-1:0] iRomInstruction,
  input  logic                   iStall,
  input  logic                   iBranchTaken,
  input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic                   oInstructionValid,
  output logic [ADDR_WIDTH-1:0]  oPC
);

  // NOP opcode in the top byte, operand bits cleared.
  localparam logic [7:0]             NOP_OPCODE = `NOP;
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD   = {NOP_OPCODE, {(INSTR_WIDTH-8){1'b0}}};

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]  ir_pc_q, ir_pc_d;

  // Next-state and register updates; default is to hold everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    ir_pc_d = ir_pc_q;

    unique case (state_q)
      // First edge after reset always fetches; stall and branch cannot apply yet.
      BOOT: begin
        ir_d    = iRomInstruction;
        ir_pc_d = pc_q;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        valid_d = 1'b1;
        state_d = RUN;
      end

      // Branch beats stall: the instruction in IR is being replaced anyway.
      RUN: begin
        if (iBranchTaken) begin
          pc_d    = iBranchTarget;
          ir_d    = NOP_WORD;
          valid_d = 1'b0;
          state_d = REDIRECT;
        end else if (!iStall) begin
          ir_d    = iRomInstruction;
          ir_pc_d = pc_q;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          valid_d = 1'b1;
        end
      end

      // IR holds a bubble, so a branch indication here refers to nothing.
      REDIRECT: begin
        if (!iStall) begin
          ir_d    = iRomInstruction;
          ir_pc_d = pc_q;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          valid_d = 1'b1;
          state_d = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State registers with asynchronous reset that discards in-flight fetches.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      ir_q    <= NOP_WORD;
      valid_q <= 1'b0;
      ir_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      ir_pc_q <= ir_pc_d;
    end
  end

  assign oRomAddress       = pc_q;
  assign oInstruction      = ir_q;
  assign oInstructionValid = valid_q;
  assign oPC               = ir_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed table-driven bench for instruction_fetch

module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] rom_addr;
  logic [27:0] rom_data;
  logic        stall;
  logic        br;
  logic [15:0] tgt;
  logic [27:0] instr;
  logic        valid;
  logic [15:0] pc;

  int n_cmp;
  int n_bad;

  instruction_fetch #(
    .ADDR_WIDTH  (16),
    .INSTR_WIDTH (28),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .iClock           (clk),
    .iReset_n         (rst_n),
    .oRomAddress      (rom_addr),
    .iRomInstruction  (rom_data),
    .iStall           (stall),
    .iBranchTaken     (br),
    .iBranchTarget    (tgt),
    .oInstruction     (instr),
    .oInstructionValid(valid),
    .oPC              (pc)
  );

  // ROM contents: word at address a is a + 0x100.
  assign rom_data = {12'h000, rom_addr} + 28'h0000100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [27:0] exp_ir;
    logic [15:0] exp_rom;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic b, logic [15:0] t,
                              logic ev, logic [15:0] ep, logic [27:0] ei, logic [15:0] er);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t;
    v.exp_valid = ev; v.exp_pc = ep; v.exp_ir = ei; v.exp_rom = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [15:0] ep,
                               input logic [27:0] ei, input logic [15:0] er);
    check({tag, ".valid"}, {31'b0, valid}, {31'b0, ev});
    check({tag, ".pc"},    {16'b0, pc},    {16'b0, ep});
    check({tag, ".ir"},    {4'b0, instr},  {4'b0, ei});
    check({tag, ".rom"},   {16'b0, rom_addr}, {16'b0, er});
  endtask

  // Drive inputs after a falling edge, clock once, check on the next falling edge.
  task automatic apply(input string tag, input vec_t v);
    stall = v.stall;
    br    = v.br;
    tgt   = v.tgt;
    @(negedge clk);
    check_outputs(tag, v.exp_valid, v.exp_pc, v.exp_ir, v.exp_rom);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    br    = 1'b0;
    tgt   = 16'h0;

    //                stall br  tgt      valid pc       ir          rom
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0000, 28'h0000100, 16'h0001));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0001, 28'h0000101, 16'h0002));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0002, 28'h0000102, 16'h0003));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0003, 28'h0000103, 16'h0004));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0004, 28'h0000104, 16'h0005));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0005, 28'h0000105, 16'h0006));
    // three stalled cycles at pc 5
    vecs.push_back(mk(1, 0, 16'h0000, 1, 16'h0005, 28'h0000105, 16'h0006));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 16'h0005, 28'h0000105, 16'h0006));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 16'h0005, 28'h0000105, 16'h0006));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0006, 28'h0000106, 16'h0007));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0007, 28'h0000107, 16'h0008));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0008, 28'h0000108, 16'h0009));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0009, 28'h0000109, 16'h000A));
    // branch to 8 while pc 9: bubble then refetch
    vecs.push_back(mk(0, 1, 16'h0008, 0, 16'h0009, 28'h0000000, 16'h0008));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0008, 28'h0000108, 16'h0009));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0009, 28'h0000109, 16'h000A));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h000A, 28'h000010A, 16'h000B));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h000B, 28'h000010B, 16'h000C));
    // branch and stall together at pc 11: branch wins
    vecs.push_back(mk(1, 1, 16'h0007, 0, 16'h000B, 28'h0000000, 16'h0007));
    // stall in the bubble holds it
    vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h000B, 28'h0000000, 16'h0007));
    // branch in the bubble is ignored
    vecs.push_back(mk(0, 1, 16'h0003, 1, 16'h0007, 28'h0000107, 16'h0008));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0008, 28'h0000108, 16'h0009));
    // branch to 0xFFFF then wrap
    vecs.push_back(mk(0, 1, 16'hFFFF, 0, 16'h0008, 28'h0000000, 16'hFFFF));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hFFFF, 28'h00100FF, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0000, 28'h0000100, 16'h0001));
    // branch to own address
    vecs.push_back(mk(0, 1, 16'h0000, 0, 16'h0000, 28'h0000000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0000, 28'h0000100, 16'h0001));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0001, 28'h0000101, 16'h0002));
    // enter a stall before the mid-operation reset
    vecs.push_back(mk(1, 0, 16'h0000, 1, 16'h0001, 28'h0000101, 16'h0002));

    // Reset state while held in reset across edges.
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset", 1'b0, 16'h0000, 28'h0000000, 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Mid-stall asynchronous reset, asserted between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 16'h0000, 28'h0000000, 16'h0000);
    @(negedge clk);
    check_outputs("rst_held", 1'b0, 16'h0000, 28'h0000000, 16'h0000);
    rst_n = 1'b1;

    // BOOT ignores stall and branch.
    apply("boot", mk(1, 1, 16'h0033, 1, 16'h0000, 28'h0000100, 16'h0001));
    apply("post_boot", mk(0, 0, 16'h0000, 1, 16'h0001, 28'h0000101, 16'h0002));
    apply("post_boot2", mk(0, 0, 16'h0000, 1, 16'h0002, 28'h0000102, 16'h0003));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
